csam_pipe_multiplier: RTL and testbench

Pipelined, parametrised carry-save array multiplier. It multiplies an A_W-bit operand by a B_W-bit operand and produces a full-width A_W+B_W-bit product. Each operation selects unsigned or two's-complement mode, and valid/ready handshakes on both sides. It replaces the fixed 16x12 combinational carry-save multiplier in the datapath where timing closure needs registered reduction stages.

---
 rtl/csam_pkg.sv | 31 +++
 rtl/csam_stage.sv | 82 ++++++++
 rtl/csam_pipe_multiplier.sv | 94 +++++++++
 tb/tb_csam_pipe_multiplier.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csam_pkg.sv
// Shared helpers for the pipelined carry-save array multiplier:
// stage count, product width and the Baugh-Wooley correction constant.
package csam_pkg;

    // Widest product the correction-constant helper can describe.
    localparam int CSAM_MAX_P_W = 128;

    // Product width: a full-width product never overflows.
    function automatic int csam_p_w(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

    // Number of carry-save reduction stages (ceil of rows / rows per stage).
    function automatic int csam_stages(input int b_w, input int rows_per_stage);
        return (b_w + rows_per_stage - 1) / rows_per_stage;
    endfunction

    // Constant folded into the carry-save vector for two's-complement operands.
    // Inverting the single-MSB partial products turns each negative weight -x
    // into ~x - 1; summing those -1 terms and the sign weight gives
    // 2^(a_w-1) + 2^(b_w-1) + 2^(a_w+b_w-1) mod 2^(a_w+b_w).
    // With square operands the first two terms merge into 2^a_w.
    function automatic logic [CSAM_MAX_P_W-1:0] csam_bw_const(input int a_w, input int b_w);
        logic [CSAM_MAX_P_W-1:0] k;
        k = (CSAM_MAX_P_W'(1) << (a_w - 1))
          + (CSAM_MAX_P_W'(1) << (b_w - 1))
          + (CSAM_MAX_P_W'(1) << (a_w + b_w - 1));
        return k;
    endfunction

endpackage

// File: rtl/csam_stage.sv
// One registered carry-save reduction stage: folds ROW_CNT partial-product
// rows, starting at multiplier bit FIRST_ROW, into the (sum, carry) pair
// with full-adder rows only, and forwards operands, mode and tag.
module csam_stage
    import csam_pkg::*;
#(
    parameter int A_W       = 16,
    parameter int B_W       = 12,
    parameter int TAG_W     = 4,
    parameter int FIRST_ROW = 0,
    parameter int ROW_CNT   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   src_valid,
    input  logic [A_W-1:0]         src_a,
    input  logic [B_W-1:0]         src_b,
    input  logic                   src_tc,
    input  logic [TAG_W-1:0]       src_tag,
    input  logic [A_W+B_W-1:0]     src_sum,
    input  logic [A_W+B_W-1:0]     src_carry,
    output logic                   valid,
    output logic [A_W-1:0]         a,
    output logic [B_W-1:0]         b,
    output logic                   tc,
    output logic [TAG_W-1:0]       tag,
    output logic [A_W+B_W-1:0]     sum,
    output logic [A_W+B_W-1:0]     carry
);

    localparam int P_W = csam_p_w(A_W, B_W);

    logic [P_W-1:0] sum_nx;
    logic [P_W-1:0] carry_nx;
    logic [P_W-1:0] row;
    logic [P_W-1:0] sum_t;
    logic [P_W-1:0] carry_t;

    // Compress each partial-product row into the carry-save pair (3:2 per bit).
    always_comb begin
        sum_nx   = src_sum;
        carry_nx = src_carry;
        row      = '0;
        sum_t    = '0;
        carry_t  = '0;
        for (int r = 0; r < ROW_CNT; r++) begin
            row = '0;
            for (int i = 0; i < A_W; i++) begin
                // In signed mode bits with exactly one operand MSB are inverted.
                row[FIRST_ROW + r + i] = (src_a[i] & src_b[FIRST_ROW + r])
                    ^ (src_tc & ((i == A_W - 1) != (FIRST_ROW + r == B_W - 1)));
            end
            sum_t    = sum_nx ^ carry_nx ^ row;
            carry_t  = ((sum_nx & carry_nx) | (sum_nx & row) | (carry_nx & row)) << 1;
            sum_nx   = sum_t;
            carry_nx = carry_t;
        end
    end

    // Stage register; frozen while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid <= 1'b0;
            a     <= '0;
            b     <= '0;
            tc    <= 1'b0;
            tag   <= '0;
            sum   <= '0;
            carry <= '0;
        end else if (en) begin
            valid <= src_valid;
            a     <= src_a;
            b     <= src_b;
            tc    <= src_tc;
            tag   <= src_tag;
            sum   <= sum_nx;
            carry <= carry_nx;
        end
    end

endmodule

// File: rtl/csam_pipe_multiplier.sv
// Pipelined carry-save array multiplier: RS reduction stages followed by a
// registered carry-propagate add. One global stall freezes every stage.
module csam_pipe_multiplier
    import csam_pkg::*;
#(
    parameter int A_W            = 16,
    parameter int B_W            = 12,
    parameter int ROWS_PER_STAGE = 4,
    parameter int TAG_W          = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [A_W-1:0]         in_a,
    input  logic [B_W-1:0]         in_b,
    input  logic                   in_tc,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [A_W+B_W-1:0]     out_p,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int P_W = csam_p_w(A_W, B_W);
    localparam int RS  = csam_stages(B_W, ROWS_PER_STAGE);
    localparam logic [P_W-1:0] BW_K = P_W'(csam_bw_const(A_W, B_W));

    logic           stall;
    logic           vld_s   [RS+1];
    logic [A_W-1:0] a_s     [RS+1];
    logic [B_W-1:0] b_s     [RS+1];
    logic           tc_s    [RS+1];
    logic [TAG_W-1:0] tag_s [RS+1];
    logic [P_W-1:0] sum_s   [RS+1];
    logic [P_W-1:0] carry_s [RS+1];

    assign stall    = out_valid & ~out_ready;
    assign in_ready = reset & ~stall;

    // Stage 0 starts from the signed-mode correction constant (or zero).
    assign vld_s[0]   = in_valid & in_ready;
    assign a_s[0]     = in_a;
    assign b_s[0]     = in_b;
    assign tc_s[0]    = in_tc;
    assign tag_s[0]   = in_tag;
    assign sum_s[0]   = in_tc ? BW_K : '0;
    assign carry_s[0] = '0;

    for (genvar g = 0; g < RS; g++) begin : g_stage
        localparam int FIRST = g * ROWS_PER_STAGE;
        localparam int LAST  = ((g + 1) * ROWS_PER_STAGE < B_W) ? (g + 1) * ROWS_PER_STAGE : B_W;

        csam_stage #(
            .A_W       (A_W),
            .B_W       (B_W),
            .TAG_W     (TAG_W),
            .FIRST_ROW (FIRST),
            .ROW_CNT   (LAST - FIRST)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .en        (~stall),
            .src_valid (vld_s[g]),
            .src_a     (a_s[g]),
            .src_b     (b_s[g]),
            .src_tc    (tc_s[g]),
            .src_tag   (tag_s[g]),
            .src_sum   (sum_s[g]),
            .src_carry (carry_s[g]),
            .valid     (vld_s[g+1]),
            .a         (a_s[g+1]),
            .b         (b_s[g+1]),
            .tc        (tc_s[g+1]),
            .tag       (tag_s[g+1]),
            .sum       (sum_s[g+1]),
            .carry     (carry_s[g+1])
        );
    end

    // Final carry-propagate add into the output register; holds during stall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_p     <= '0;
            out_tag   <= '0;
        end else if (!stall) begin
            out_valid <= vld_s[RS];
            out_p     <= sum_s[RS] + carry_s[RS];
            out_tag   <= tag_s[RS];
        end
    end

endmodule

// File: tb/tb_csam_pipe_multiplier.sv
// Self-checking bench for csam_pipe_multiplier at default parameters.
module tb_csam_pipe_multiplier;

    localparam int A_W   = 16;
    localparam int B_W   = 12;
    localparam int RPS   = 4;
    localparam int TAG_W = 4;
    localparam int P_W   = A_W + B_W;
    localparam int LAT   = 4;
    localparam int NVEC  = 12;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [A_W-1:0]   in_a = '0;
    logic [B_W-1:0]   in_b = '0;
    logic             in_tc = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [P_W-1:0]   out_p;
    logic [TAG_W-1:0] out_tag;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [A_W-1:0]   a;
        logic [B_W-1:0]   b;
        logic             tc;
        logic [TAG_W-1:0] tag;
        logic [P_W-1:0]   p;
    } vec_t;

    typedef struct {
        logic [P_W-1:0]   p;
        logic [TAG_W-1:0] tag;
    } exp_t;

    vec_t           vecs [NVEC];
    exp_t           exp_q [$];
    logic [P_W-1:0] drv_exp = '0;
    int             pushes = 0;
    int             pops = 0;
    int             discarded = 0;
    int             stall_cnt = 0;
    int             last_run = 0;
    bit             rnd_done = 0;

    always #5 clk = ~clk;

    csam_pipe_multiplier #(
        .A_W            (A_W),
        .B_W            (B_W),
        .ROWS_PER_STAGE (RPS),
        .TAG_W          (TAG_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tc     (in_tc),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference product from sign/zero-extended operands.
    function automatic logic [P_W-1:0] ref_mul(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                               input logic tc);
        logic [P_W-1:0] ea;
        logic [P_W-1:0] eb;
        ea = {{B_W{tc & a[A_W-1]}}, a};
        eb = {{A_W{tc & b[B_W-1]}}, b};
        return ea * eb;
    endfunction

    // Present one operation and hold it until it is taken; returns at posedge+1.
    task automatic send(input logic [A_W-1:0] a, input logic [B_W-1:0] b, input logic tc,
                        input logic [TAG_W-1:0] tag, input logic [P_W-1:0] p);
        bit ok = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tc    = tc;
        in_tag   = tag;
        drv_exp  = p;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        check("send_accepted", 64'(ok), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1;
                break;
            end
        end
        check("drain_done", 64'(ok), 64'(1));
        @(posedge clk);
        #1;
    endtask

    // Output scoreboard, stall-hold and handshake bookkeeping, sampled at negedge.
    initial begin
        exp_t             e;
        bit               prev_stall = 0;
        logic [P_W-1:0]   prev_p = '0;
        logic [TAG_W-1:0] prev_tag = '0;
        int               run = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                discarded += exp_q.size();
                exp_q.delete();
                prev_stall = 0;
                run = 0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold_valid", 64'(out_valid), 64'(1));
                    check("stall_hold_p", 64'(out_p), 64'(prev_p));
                    check("stall_hold_tag", 64'(out_tag), 64'(prev_tag));
                end
                if (out_valid && !out_ready) begin
                    stall_cnt++;
                    check("in_ready_during_stall", 64'(in_ready), 64'(0));
                end
                if (out_valid && out_ready) begin
                    pops++;
                    run++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("out_p", 64'(out_p), 64'(e.p));
                        check("out_tag", 64'(out_tag), 64'(e.tag));
                    end
                end else begin
                    if (run != 0) last_run = run;
                    run = 0;
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back('{drv_exp, in_tag});
                    pushes++;
                end
                prev_stall = out_valid && !out_ready;
                prev_p     = out_p;
                prev_tag   = out_tag;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        bit seen;
        int pops0;
        int stall0;
        int ghosts;

        vecs[0]  = '{16'hFFFF, 12'hFFF, 1'b0, 4'h3, 28'hFFEF001};
        vecs[1]  = '{16'hFFFF, 12'hFFF, 1'b1, 4'h1, 28'h0000001};
        vecs[2]  = '{16'h8000, 12'h7FF, 1'b1, 4'h2, 28'hC008000};
        vecs[3]  = '{16'h8000, 12'h800, 1'b1, 4'h4, 28'h4000000};
        vecs[4]  = '{16'h0000, 12'h000, 1'b0, 4'h5, 28'h0000000};
        vecs[5]  = '{16'h1234, 12'h056, 1'b0, 4'h6, 28'h0061D78};
        vecs[6]  = '{16'h0003, 12'hFFD, 1'b1, 4'h7, 28'hFFFFFF7};
        vecs[7]  = '{16'h7FFF, 12'h7FF, 1'b1, 4'h8, 28'h3FF7801};
        vecs[8]  = '{16'h8000, 12'h7FF, 1'b0, 4'h9, 28'h3FF8000};
        vecs[9]  = '{16'hFFFF, 12'h001, 1'b1, 4'hA, 28'hFFFFFFF};
        vecs[10] = '{16'h0001, 12'h800, 1'b1, 4'hB, 28'hFFFF800};
        vecs[11] = '{16'h8000, 12'h800, 1'b0, 4'hC, 28'h4000000};

        // Reset with operands offered: nothing may be taken.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 16'hFFFF;
        in_b      = 12'hFFF;
        in_tag    = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_out_p", 64'(out_p), 64'(0));
        check("reset_out_tag", 64'(out_tag), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", 64'(in_ready), 64'(1));
        check("out_valid_after_reset", 64'(out_valid), 64'(0));

        // Single op: valid appears LAT cycles after the cycle the operand was taken.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a     = vecs[0].a;
        in_b     = vecs[0].b;
        in_tc    = vecs[0].tc;
        in_tag   = vecs[0].tag;
        drv_exp  = vecs[0].p;
        @(negedge clk);
        check("latency_accept", 64'(in_ready), 64'(1));
        cyc  = 0;
        seen = 0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            cyc++;
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        check("latency_seen", 64'(seen), 64'(1));
        check("latency_cycles", 64'(cyc), 64'(LAT));
        drain();

        // Table vectors back to back: one result per cycle, in order.
        for (int i = 0; i < NVEC; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].tc, vecs[i].tag, vecs[i].p);
        end
        in_valid = 1'b0;
        drain();
        check("b2b_run_length", 64'(last_run), 64'(NVEC));

        // Backpressure: 8 ops, consumer stalls 3 cycles mid-stream.
        pops0  = pops;
        stall0 = stall_cnt;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [A_W-1:0] a;
                    logic [B_W-1:0] b;
                    a = A_W'($urandom());
                    b = B_W'($urandom());
                    send(a, b, 1'(i), TAG_W'(i), ref_mul(a, b, 1'(i)));
                end
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_output_count", 64'(pops - pops0), 64'(8));
        check("bp_stall_cycles", 64'(stall_cnt - stall0), 64'(3));

        // Reset with three ops in flight: all discarded, no output afterwards.
        for (int i = 0; i < 3; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].tc, vecs[i].tag, vecs[i].p);
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        check("midreset_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("midreset_out_valid", 64'(out_valid), 64'(0));
        check("midreset_out_p", 64'(out_p), 64'(0));
        check("midreset_discarded", 64'(discarded), 64'(3));
        ghosts = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) ghosts++;
        end
        check("midreset_ghost_outputs", 64'(ghosts), 64'(0));
        @(posedge clk);
        #1;

        // Random ops, random gaps and random consumer backpressure.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [A_W-1:0] a;
                    logic [B_W-1:0] b;
                    logic           tc;
                    a  = A_W'($urandom());
                    b  = B_W'($urandom());
                    tc = 1'($urandom());
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    send(a, b, tc, TAG_W'(i), ref_mul(a, b, tc));
                end
                in_valid = 1'b0;
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("total_conservation", 64'(pushes), 64'(pops + discarded));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
